// File: rtl/sram_responder_pkg.sv
// Shared types and helpers for the SRAM responder and its dual-port bank.
// Holds the state encoding, the bus widths and the byte-address to word-index mapping.
package sram_responder_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Drops the byte offset and folds higher address bits away so addresses alias modulo depth.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> 2) & ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/sram_dp_bank.sv
// True dual-port byte-enabled word array with read-first registered outputs.
// One-cycle read latency, no backpressure; on same-byte write collisions port B wins.
module sram_dp_bank
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_a_rd,
    input  logic [BE_W-1:0]   i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [WORD_W-1:0] i_a_wdata,
    output logic [WORD_W-1:0] o_a_rdata,
    input  logic              i_b_rd,
    input  logic [BE_W-1:0]   i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [WORD_W-1:0] i_b_wdata,
    output logic [WORD_W-1:0] o_b_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_a_rdata;
    logic [WORD_W-1:0] r_b_rdata;

    // Port B updates are scheduled after port A so its bytes take precedence on collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (i_a_we[i]) r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
        end
        for (int i = 0; i < BE_W; i++) begin
            if (i_b_we[i]) r_mem[i_b_addr][8*i +: 8] <= i_b_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (i_a_rd) r_a_rdata <= r_mem[i_a_addr];
            if (i_b_rd) r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/sram_responder.sv
// Instruction/data SRAM responder with a post-reset clear engine in front of a dual-port bank.
// One-cycle read latency, never stalls; port inputs are ignored while the clear engine runs.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W        = 12,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_sram_en,
    input  logic [BE_W-1:0]   inst_sram_we,
    input  logic [31:0]       inst_sram_addr,
    input  logic [WORD_W-1:0] inst_sram_wdata,
    output logic [WORD_W-1:0] inst_sram_rdata,
    input  logic              data_sram_en,
    input  logic [BE_W-1:0]   data_sram_we,
    input  logic [31:0]       data_sram_addr,
    input  logic [WORD_W-1:0] data_sram_wdata,
    output logic [WORD_W-1:0] data_sram_rdata,
    output logic              init_busy
);

    localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? CLEAR : READY;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    logic              w_a_rd;
    logic [BE_W-1:0]   w_a_we;
    logic [ADDR_W-1:0] w_a_addr;
    logic [WORD_W-1:0] w_a_wdata;
    logic              w_b_rd;
    logic [BE_W-1:0]   w_b_we;
    logic [ADDR_W-1:0] w_b_addr;
    logic              w_busy;
    logic [ADDR_W-1:0] w_inst_idx;
    logic [ADDR_W-1:0] w_data_idx;

    assign w_inst_idx = ADDR_W'(word_index(inst_sram_addr, ADDR_W));
    assign w_data_idx = ADDR_W'(word_index(data_sram_addr, ADDR_W));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The clear engine borrows port A's write path; its reads stay disabled so rdata holds 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy      = 1'b0;
        w_a_rd      = 1'b0;
        w_a_we      = '0;
        w_a_addr    = w_inst_idx;
        w_a_wdata   = inst_sram_wdata;
        w_b_rd      = 1'b0;
        w_b_we      = '0;
        w_b_addr    = w_data_idx;
        case (r_state)
            CLEAR: begin
                w_busy    = 1'b1;
                w_a_we    = '1;
                w_a_addr  = r_cnt;
                w_a_wdata = '0;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = READY;
            end
            READY: begin
                w_a_rd = inst_sram_en;
                w_a_we = inst_sram_en ? inst_sram_we : '0;
                w_b_rd = data_sram_en;
                w_b_we = data_sram_en ? data_sram_we : '0;
            end
            default: w_state_nxt = RST_STATE;
        endcase
    end

    assign init_busy = w_busy;

    sram_dp_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (resetn),
        .i_a_rd    (w_a_rd),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_a_wdata),
        .o_a_rdata (inst_sram_rdata),
        .i_b_rd    (w_b_rd),
        .i_b_we    (w_b_we),
        .i_b_addr  (w_b_addr),
        .i_b_wdata (data_sram_wdata),
        .o_b_rdata (data_sram_rdata)
    );

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a 16-word array and the clear engine enabled.
module tb_sram_responder;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        init_busy;

    int n_checks = 0;
    int n_fail   = 0;

    sram_responder #(
        .ADDR_W        (4),
        .INIT_ON_RESET (1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .init_busy       (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ien;
        logic [3:0]  iwe;
        logic [31:0] iaddr;
        logic [31:0] iwdata;
        logic        den;
        logic [3:0]  dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_sram_en = 0; inst_sram_we = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_en = 0; data_sram_we = 0; data_sram_addr = 0; data_sram_wdata = 0;
    endtask

    // Counts edges after reset release until init_busy drops; bounded so a stuck engine still ends.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(n), 32'd16);
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        check("reset_inst_rdata", inst_sram_rdata, 32'h0);
        check("reset_data_rdata", data_sram_rdata, 32'h0);
        check("reset_busy", 32'(init_busy), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        count_busy("clear_len_first");

        //            ien iwe    iaddr          iwdata         den dwe    daddr          dwdata         exp_i          exp_d
        vecs[0]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'h0, 32'h0,         32'h0,         32'h0,         32'h0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'hF, 32'h10,        32'hDEADBEEF,  32'h0,         32'h0};
        vecs[2]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'h5, 32'h10,        32'h11223344,  32'h0,         32'hDEADBEEF};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'h0, 32'h10,        32'h0,         32'h0,         32'hDE22BE44};
        vecs[4]  = '{1'b1, 4'hF, 32'h8,         32'hAAAAAAAA,  1'b1, 4'h3, 32'h8,         32'h55555555,  32'h0,         32'h0};
        vecs[5]  = '{1'b1, 4'h0, 32'h8,         32'h0,         1'b1, 4'h0, 32'h8,         32'h0,         32'hAAAA5555,  32'hAAAA5555};
        vecs[6]  = '{1'b1, 4'h0, 32'h8,         32'h0,         1'b1, 4'hF, 32'h8,         32'h12345678,  32'hAAAA5555,  32'hAAAA5555};
        vecs[7]  = '{1'b1, 4'h0, 32'h10,        32'h0,         1'b1, 4'h0, 32'h8,         32'h0,         32'hDE22BE44,  32'h12345678};
        for (int k = 8; k < 13; k++)
            vecs[k] = '{1'b0, 4'hF, 32'h4,      32'hFFFFFFFF,  1'b0, 4'hF, 32'h4,         32'hFFFFFFFF,  32'hDE22BE44,  32'h12345678};
        vecs[13] = '{1'b1, 4'h0, 32'h4,         32'h0,         1'b1, 4'h0, 32'h4,         32'h0,         32'h0,         32'h0};
        vecs[14] = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 4'hF, 32'h44,        32'hCAFEF00D,  32'h0,         32'h0};
        vecs[15] = '{1'b1, 4'h0, 32'h44,        32'h0,         1'b1, 4'h0, 32'h4,         32'h0,         32'hCAFEF00D,  32'hCAFEF00D};
        vecs[16] = '{1'b1, 4'h0, 32'h7,         32'h0,         1'b1, 4'h0, 32'hFFFFFF13,  32'h0,         32'hCAFEF00D,  32'hDE22BE44};

        check("ready_busy_low", 32'(init_busy), 32'd0);
        for (int k = 0; k < 17; k++) begin
            inst_sram_en = vecs[k].ien;    inst_sram_we = vecs[k].iwe;
            inst_sram_addr = vecs[k].iaddr; inst_sram_wdata = vecs[k].iwdata;
            data_sram_en = vecs[k].den;    data_sram_we = vecs[k].dwe;
            data_sram_addr = vecs[k].daddr; data_sram_wdata = vecs[k].dwdata;
            @(posedge clk); #1;
            check($sformatf("vec%0d_inst", k), inst_sram_rdata, vecs[k].exp_i);
            check($sformatf("vec%0d_data", k), data_sram_rdata, vecs[k].exp_d);
        end
        idle_inputs();

        // Reset in READY clears the read registers without waiting for a clock.
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("rst_ready_inst", inst_sram_rdata, 32'h0);
        check("rst_ready_data", data_sram_rdata, 32'h0);
        check("rst_ready_busy", 32'(init_busy), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
        end
        check("clear7_busy", 32'(init_busy), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("rst_clear_busy", 32'(init_busy), 32'd1);
        check("rst_clear_data", data_sram_rdata, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        // Port writes attempted during CLEAR must be ignored.
        data_sram_en = 1'b1; data_sram_we = 4'hF; data_sram_addr = 32'hC; data_sram_wdata = 32'hFFFFFFFF;
        inst_sram_en = 1'b1; inst_sram_we = 4'hF; inst_sram_addr = 32'h20; inst_sram_wdata = 32'hFFFFFFFF;
        count_busy("clear_len_restart");
        check("clear_hold_data", data_sram_rdata, 32'h0);
        check("clear_hold_inst", inst_sram_rdata, 32'h0);
        idle_inputs();

        data_sram_en = 1'b1; data_sram_addr = 32'h8;
        inst_sram_en = 1'b1; inst_sram_addr = 32'h4;
        @(posedge clk); #1;
        check("post_clear_w2", data_sram_rdata, 32'h0);
        check("post_clear_w1", inst_sram_rdata, 32'h0);
        data_sram_addr = 32'hC;
        inst_sram_addr = 32'h10;
        @(posedge clk); #1;
        check("post_clear_w3", data_sram_rdata, 32'h0);
        check("post_clear_w4", inst_sram_rdata, 32'h0);
        data_sram_addr = 32'h20;
        @(posedge clk); #1;
        check("post_clear_w8", data_sram_rdata, 32'h0);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the two core SRAM ports: instruction port (read/write capable, in practice read-only) and data port (read/write with byte enables).
- Answers every enabled access with fixed one-cycle read latency and no backpressure, matching what the pipeline front and MEM stages expect.
- Includes a post-reset clear engine that zeroes the array before service begins.
- Used in simulation and FPGA builds in place of vendor block RAM.

Parameters:
- ADDR_W, 12: word-address width; depth is 2**ADDR_W 32-bit words.
- INIT_ON_RESET, 1: 1 runs the clear engine after reset; 0 skips it, leaves array contents unchanged and goes straight to READY.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- inst_sram_en  in  1  port A access enable.
- inst_sram_we  in  4  port A byte write enables.
- inst_sram_addr  in  32  port A byte address.
- inst_sram_wdata  in  32  port A write data.
- inst_sram_rdata  out  32  port A read data, registered.
- data_sram_en  in  1  port B access enable.
- data_sram_we  in  4  port B byte write enables.
- data_sram_addr  in  32  port B byte address.
- data_sram_wdata  in  32  port B write data.
- data_sram_rdata  out  32  port B read data, registered.
- init_busy  out  1  high while the clear engine runs.

Behaviour:
- Reset (async assert, sync release):
  - both rdata = 0.
  - state = CLEAR if INIT_ON_RESET, else READY.
  - clear counter = 0; init_busy = INIT_ON_RESET.
  - Array is never reset directly.
- Addressing:
  - word index = addr[ADDR_W+1:2].
  - addr[1:0] is ignored; bits above ADDR_W+1 are ignored, so addresses alias modulo depth.
- READY, port access with en=1:
  - Cycle N: sample addr/we/wdata.
  - Cycle N+1: rdata = word content before any cycle-N write (read-first), including when we != 0.
  - Writes commit at the cycle-N edge; byte i is written from wdata[8i+7:8i] only where we[i]=1.
- en=0: no read, no write even if we != 0; rdata holds its previous value indefinitely.
- Same-word collision in one cycle:
  - Both ports write: per byte, port B (data) wins where both enables are set; bytes written by only one port take that port's value.
  - One port reads while the other writes: the reader gets the old word.
  - Both read: both get the same word.
- CLEAR:
  - Each cycle writes 0 to word[counter], then counter increments.
  - All port inputs are ignored (no writes); both rdata are held at 0.
  - After writing word 2**ADDR_W-1 the state goes to READY and init_busy drops on that same edge. CLEAR therefore lasts exactly 2**ADDR_W cycles after reset release.
  - The first access accepted is the one presented in the first cycle with init_busy=0.
- Reset asserted mid-CLEAR or mid-READY:
  - Outputs go to reset values immediately.
  - CLEAR restarts from counter 0; partially cleared contents are not relied upon.
  - An in-flight write on the reset edge is dropped.
- No X propagation: reading an uncleared word with INIT_ON_RESET=0 returns array contents as-is; the bench preloads via hierarchy.

Decomposition:
- Shared package holds:
  - state enum {CLEAR, READY}.
  - WORD_W=32, BE_W=4.
  - helper to derive word index from byte address given ADDR_W.
- One natural sub-module, sram_dp_bank: the true-dual-port byte-enabled array with read-first registered outputs and the B-wins collision rule.
- The top level holds the clear FSM/counter and the input gating.

Test Plan (ADDR_W=4, so 16 words):
- Reset release with INIT_ON_RESET=1: init_busy high for exactly 16 cycles. A data read of 0x0 in the first READY cycle returns 0x00000000 one cycle later.
- Data write 0x0000_0010 with we=4'b1111, wdata 0xDEADBEEF. Next cycle, write the same address with we=4'b0101, wdata 0x11223344. A following read returns 0xDE22BE44, and the read issued with the second write returns 0xDEADBEEF.
- Same cycle: inst writes 0xAAAAAAAA with we=1111 and data writes 0x55555555 with we=0011 to addr 0x8. A later read gives 0xAAAA5555. Inst read of 0x8 while data writes 0x8 returns the pre-write value.
- en=0, we=1111 to addr 0x4: contents unchanged. rdata keeps the previous read value over 5 idle cycles.
- Aliasing: write 0xCAFEF00D to addr 0x44; a read of 0x04 returns 0xCAFEF00D.
- Assert resetn low at clear cycle 7: rdata goes to 0 asynchronously. After release, init_busy lasts 16 full cycles and a word written before reset reads back 0.
